aes256_dec_word_bridge: RTL and testbench

- Upstream/downstream adapter for the AES-256 decryption core (`AES256_dec`).
- Collects four 32-bit bus words into one 128-bit ciphertext block and drives it to the core on `inpAES` with a one-cycle `ctrl_dataIn` pulse.
- Waits for `ctrl_dataOut`, captures `outAES`, then returns the plaintext as four 32-bit words over a valid/ready read stream.
- Includes a watchdog that aborts if the core never answers.

---
 rtl/aes256_dec_word_bridge.sv | 132 +++++++++++++
 tb/tb_aes256_dec_word_bridge.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes256_dec_word_bridge.sv
// Word-serial front end for the AES-256 decryption core: packs four 32-bit writes into one
// ciphertext block, starts the core, and streams the four plaintext words back out.
module aes256_dec_word_bridge #(
    parameter int TIMEOUT = 64,
    parameter int CW      = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [31:0]  wr_data,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic [31:0]  rd_data,
    output logic [127:0] inpAES,
    output logic         ctrl_dataIn,
    input  logic [127:0] outAES,
    input  logic         ctrl_dataOut,
    output logic         busy,
    output logic         err_timeout
);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [CW-1:0] WD_LIMIT = CW'(TIMEOUT - 1);

    state_t         r_state;
    state_t         w_next;
    logic [1:0]     r_idx;
    logic [CW-1:0]  r_wd;
    logic [127:0]   r_inbuf;
    logic [127:0]   r_outbuf;
    logic           r_err;
    logic           w_wr_hs;
    logic           w_rd_hs;
    logic           w_capture;
    logic           w_timeout;
    logic [1:0]     w_slot;

    // Slot 3 is the most significant word, so the first word in/out is bits [127:96].
    assign w_slot      = ~r_idx;
    assign inpAES      = r_inbuf;
    assign rd_data     = r_outbuf[{w_slot, 5'b0} +: 32];
    assign busy        = (r_state != ST_FILL);
    assign err_timeout = r_err;

    always_comb begin
        w_next      = r_state;
        wr_ready    = 1'b0;
        ctrl_dataIn = 1'b0;
        rd_valid    = 1'b0;
        w_wr_hs     = 1'b0;
        w_rd_hs     = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_FILL: begin
                wr_ready = 1'b1;
                w_wr_hs  = wr_valid;
                if (wr_valid && (r_idx == 2'd3)) begin
                    w_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                ctrl_dataIn = 1'b1;
                w_next      = ST_WAIT;
            end
            ST_WAIT: begin
                // A result on the final watchdog cycle still counts as a capture.
                if (ctrl_dataOut) begin
                    w_capture = 1'b1;
                    w_next    = ST_DRAIN;
                end else if (r_wd == WD_LIMIT) begin
                    w_timeout = 1'b1;
                    w_next    = ST_FILL;
                end
            end
            ST_DRAIN: begin
                rd_valid = 1'b1;
                w_rd_hs  = rd_ready;
                if (rd_ready && (r_idx == 2'd3)) begin
                    w_next = ST_FILL;
                end
            end
            default: w_next = ST_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx    <= 2'd0;
            r_wd     <= '0;
            r_inbuf  <= '0;
            r_outbuf <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_timeout) begin
                r_idx <= 2'd0;
            end else if (w_wr_hs || w_rd_hs) begin
                r_idx <= r_idx + 2'd1;
            end
            if (w_wr_hs) begin
                r_inbuf[{w_slot, 5'b0} +: 32] <= wr_data;
            end
            if (r_state == ST_ISSUE) begin
                r_wd <= '0;
            end else if ((r_state == ST_WAIT) && !ctrl_dataOut && (r_wd != WD_LIMIT)) begin
                r_wd <= r_wd + 1'b1;
            end
            if (w_capture) begin
                r_outbuf <= outAES;
                r_err    <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes256_dec_word_bridge.sv
// Bench for aes256_dec_word_bridge: a stub core answers after a chosen delay, a scoreboard
// queue holds the plaintext words the consumer should see, and a monitor compares them.
module tb_aes256_dec_word_bridge;

    localparam int TO = 8;

    logic         clk;
    logic         reset;
    logic         wr_valid;
    logic         wr_ready;
    logic [31:0]  wr_data;
    logic         rd_valid;
    logic         rd_ready;
    logic [31:0]  rd_data;
    logic [127:0] inpAES;
    logic         ctrl_dataIn;
    logic [127:0] outAES;
    logic         ctrl_dataOut;
    logic         busy;
    logic         err_timeout;

    aes256_dec_word_bridge #(.TIMEOUT(TO), .CW(16)) dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .inpAES(inpAES), .ctrl_dataIn(ctrl_dataIn),
        .outAES(outAES), .ctrl_dataOut(ctrl_dataOut),
        .busy(busy), .err_timeout(err_timeout)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0]  exp_rd[$];
    logic [127:0] exp_blk[$];
    int           stub_delay = -1;
    logic [127:0] stub_resp = '0;
    bit           spur_req = 1'b0;
    int           rd_mode = 0;
    int           rd_count = 0;
    int           pulse_cnt = 0;
    bit           exp_err = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic note_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=event-missing-or-unexpected expected=none", nm);
    endtask

    // Consumer: 0 = always ready, 1 = ready pattern 1-0-0-1, other = never ready.
    initial begin
        int phase;
        phase = 0;
        rd_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rd_mode)
                0: rd_ready = 1'b1;
                1: begin
                    rd_ready = (phase == 0) || (phase == 3);
                    phase = (phase + 1) % 4;
                end
                default: rd_ready = 1'b0;
            endcase
        end
    end

    // Stub core: answers stub_delay cycles after the start pulse; injects spurious results on request.
    initial begin
        int cnt;
        bit fire;
        logic [127:0] resp_l;
        cnt = -1;
        resp_l = '0;
        ctrl_dataOut = 1'b0;
        outAES = '0;
        forever begin
            @(posedge clk); #1;
            fire = 1'b0;
            if (ctrl_dataIn === 1'b1) begin
                cnt = (stub_delay > 0) ? stub_delay : -1;
                resp_l = stub_resp;
                if (exp_blk.size() == 0) note_fail("issue_unexpected");
                else chk("issue_inpAES", inpAES, exp_blk.pop_front());
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    fire = 1'b1;
                    cnt = -1;
                end
            end
            if (fire) begin
                ctrl_dataOut = 1'b1;
                outAES = resp_l;
            end else begin
                ctrl_dataOut = spur_req;
                spur_req = 1'b0;
                outAES = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    end

    // Monitor: scoreboard pops on every read handshake; also checks hold and write lockout.
    initial begin
        bit stall_prev;
        logic [31:0] held;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (ctrl_dataIn === 1'b1) pulse_cnt++;
            if (rd_valid === 1'b1) begin
                chk("wr_ready_in_drain", wr_ready, 0);
                if (stall_prev) chk("rd_hold", rd_data, held);
            end
            if (rd_valid === 1'b1 && rd_ready === 1'b1 && reset === 1'b0) begin
                if (exp_rd.size() == 0) note_fail("rd_unexpected");
                else chk("rd_data", rd_data, exp_rd.pop_front());
                rd_count++;
            end
            stall_prev = (rd_valid === 1'b1) && (rd_ready === 1'b0) && (reset === 1'b0);
            held = rd_data;
        end
    end

    initial begin
        #600000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench timed out");
    end

    // Call at posedge+1; returns at posedge+1 in the cycle after the 4th write handshake.
    task automatic start_block(input logic [127:0] blk, input logic [127:0] resp,
                               input int delay, input int maxgap);
        stub_delay = delay;
        stub_resp = resp;
        exp_blk.push_back(blk);
        if (delay >= 1 && delay <= TO) begin
            for (int i = 0; i < 4; i++) exp_rd.push_back(resp[127 - 32*i -: 32]);
            exp_err = 1'b0;
        end else begin
            exp_err = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            int t;
            wr_valid = 1'b0;
            repeat ($urandom_range(maxgap, 0)) begin @(posedge clk); #1; end
            wr_valid = 1'b1;
            wr_data = blk[127 - 32*i -: 32];
            t = 0;
            @(negedge clk);
            while (wr_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
            if (wr_ready !== 1'b1) note_fail("wr_accept_timeout");
            @(posedge clk); #1;
            wr_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input string nm);
        int t;
        t = 0;
        @(negedge clk);
        while (busy !== 1'b0 && t < 300) begin @(negedge clk); t++; end
        if (busy !== 1'b0) note_fail({nm, "_idle_timeout"});
        chk({nm, "_err"}, err_timeout, exp_err);
        chk({nm, "_left"}, exp_rd.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic run_block(input string nm, input logic [127:0] blk, input logic [127:0] resp,
                             input int delay, input int maxgap);
        start_block(blk, resp, delay, maxgap);
        wait_idle(nm);
    endtask

    task automatic pulse_reset(input string nm);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_rd.delete();
        exp_blk.delete();
        exp_err = 1'b0;
        @(negedge clk);
        chk({nm, "_rd_valid"}, rd_valid, 0);
        chk({nm, "_ctrl_dataIn"}, ctrl_dataIn, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_err"}, err_timeout, 0);
        chk({nm, "_inpAES"}, inpAES, 0);
        chk({nm, "_rd_data"}, rd_data, 0);
        @(posedge clk); #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int p0;
        int base;
        int t;
        reset = 1'b1;
        wr_valid = 1'b0;
        wr_data = '0;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_inpAES", inpAES, 0);
        chk("rst_ctrl_dataIn", ctrl_dataIn, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Known-answer block, back-to-back writes.
        rd_mode = 0;
        p0 = pulse_cnt;
        run_block("t1", 128'h7a584d99febc93ead6b3563cc4ad3a63,
                  128'h000102030405060708090a0b0c0d0e0f, 5, 0);
        chk("t1_inpAES", inpAES, 128'h7a584d99febc93ead6b3563cc4ad3a63);
        chk("t1_pulses", pulse_cnt - p0, 1);
        chk("t1_busy", busy, 0);

        // Backpressure and write gaps.
        rd_mode = 1;
        for (int k = 0; k < 3; k++) run_block("t2", rnd128(), rnd128(), $urandom_range(7, 1), 3);

        // Core never answers: error exactly TO cycles after the start pulse.
        rd_mode = 0;
        start_block(rnd128(), rnd128(), -1, 1);
        @(negedge clk);
        chk("t3_pulse", ctrl_dataIn, 1);
        repeat (TO) @(negedge clk);
        chk("t3_err_before", err_timeout, 0);
        chk("t3_busy_before", busy, 1);
        @(negedge clk);
        chk("t3_err_set", err_timeout, 1);
        chk("t3_busy_after", busy, 0);
        chk("t3_no_rd", rd_valid, 0);
        @(posedge clk); #1;
        // Spurious result while filling must neither capture nor clear the error.
        spur_req = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("t4_err_sticky", err_timeout, 1);
        chk("t4_fill_busy", busy, 0);
        run_block("t3_recover", rnd128(), rnd128(), 3, 0);

        // Spurious results during drain with backpressure.
        rd_mode = 1;
        start_block(rnd128(), rnd128(), 2, 1);
        t = 0;
        @(negedge clk);
        while (rd_valid !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        if (rd_valid !== 1'b1) note_fail("t4_no_drain");
        spur_req = 1'b1;
        repeat (3) @(negedge clk);
        spur_req = 1'b1;
        wait_idle("t4");

        // Reset in WAIT; the late core answer lands in FILL and must be ignored.
        rd_mode = 0;
        start_block(rnd128(), rnd128(), 6, 0);
        @(posedge clk); #1;
        pulse_reset("t5_wait");
        run_block("t5_after_wait", rnd128(), rnd128(), 4, 0);

        // Reset in DRAIN after two reads.
        base = rd_count;
        start_block(rnd128(), rnd128(), 2, 0);
        t = 0;
        do begin @(negedge clk); #1; t++; end while (rd_count < base + 2 && t < 100);
        if (rd_count < base + 2) note_fail("t5_two_reads");
        rd_mode = 2;
        @(posedge clk); #1;
        pulse_reset("t5_drain");
        rd_mode = 0;
        run_block("t5_after_drain", rnd128(), rnd128(), 3, 1);

        // Watchdog boundary: one cycle late times out, exactly on the limit captures.
        run_block("t6_late", rnd128(), rnd128(), TO + 1, 0);
        repeat (4) begin @(posedge clk); #1; end
        run_block("t6_race", rnd128(), rnd128(), TO, 0);

        // Random mix including timeouts.
        for (int k = 0; k < 8; k++) begin
            rd_mode = $urandom_range(1, 0);
            run_block("rand", rnd128(), rnd128(), $urandom_range(TO + 2, 1), 2);
            repeat (3) begin @(posedge clk); #1; end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
